// File: rtl/spu_issue_scoreboard.sv
// rtl/spu_issue_scoreboard.sv - per-register latency scoreboard with RAW hazard detection for a dual-issue pipe bundle
module spu_issue_scoreboard #(
    parameter int NUM_PIPES    = 2,
    parameter int NUM_REGS     = 128,
    parameter int LAT_W        = 3,
    parameter int SRC_PER_PIPE = 3
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic [NUM_PIPES-1:0]                               issue_valid,
    input  logic [NUM_PIPES-1:0]                               issue_wr,
    input  logic [NUM_PIPES*$clog2(NUM_REGS)-1:0]              issue_rt,
    input  logic [NUM_PIPES*LAT_W-1:0]                         issue_lat,
    input  logic [NUM_PIPES*SRC_PER_PIPE*$clog2(NUM_REGS)-1:0] src_addr,
    input  logic [NUM_PIPES*SRC_PER_PIPE-1:0]                  src_used,
    input  logic                                               flush,
    output logic [NUM_PIPES-1:0]                               hazard,
    output logic                                               stall,
    output logic [NUM_REGS-1:0]                                busy,
    output logic [$clog2(NUM_REGS+1)-1:0]                      busy_cnt
);

    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS+1);

    logic [LAT_W-1:0]     cnt_q   [NUM_REGS];
    logic [LAT_W-1:0]     cnt_nxt [NUM_REGS];
    logic [CW-1:0]        busy_cnt_nxt;
    logic [NUM_PIPES-1:0] accept;
    logic [RW-1:0]        src_a;
    logic                 hit;

    // A source hits if its register is pending, or an older pipe in this bundle
    // writes it with a tracked (nonzero) latency.
    always_comb begin
        hazard = '0;
        src_a  = '0;
        hit    = 1'b0;
        for (int p = 0; p < NUM_PIPES; p++) begin
            hit = 1'b0;
            for (int s = 0; s < SRC_PER_PIPE; s++) begin
                src_a = src_addr[(p*SRC_PER_PIPE+s)*RW +: RW];
                if (src_used[p*SRC_PER_PIPE+s]) begin
                    if (cnt_q[src_a] != '0)
                        hit = 1'b1;
                    for (int q = 0; q < p; q++) begin
                        if (issue_valid[q] && issue_wr[q] &&
                            (issue_lat[q*LAT_W +: LAT_W] != '0) &&
                            (issue_rt[q*RW +: RW] == src_a))
                            hit = 1'b1;
                    end
                end
            end
            hazard[p] = reset & issue_valid[p] & hit;
        end
    end

    assign stall  = |hazard;
    assign accept = issue_valid & issue_wr & {NUM_PIPES{~stall & ~flush}};

    // Zero-latency writes never beat the decremented value, so they stay untracked.
    always_comb begin
        busy_cnt_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
            for (int p = 0; p < NUM_PIPES; p++) begin
                if (accept[p] && (issue_rt[p*RW +: RW] == RW'(r)) &&
                    (issue_lat[p*LAT_W +: LAT_W] > cnt_nxt[r]))
                    cnt_nxt[r] = issue_lat[p*LAT_W +: LAT_W];
            end
            if (flush)
                cnt_nxt[r] = '0;
            busy_cnt_nxt = busy_cnt_nxt + CW'(cnt_nxt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
            busy_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= cnt_nxt[r];
            busy_cnt <= busy_cnt_nxt;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++)
            busy[r] = (cnt_q[r] != '0);
    end

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// tb/tb_spu_issue_scoreboard.sv - directed self-checking bench for spu_issue_scoreboard
module tb_spu_issue_scoreboard;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   issue_valid;
    logic [1:0]   issue_wr;
    logic [13:0]  issue_rt;
    logic [5:0]   issue_lat;
    logic [41:0]  src_addr;
    logic [5:0]   src_used;
    logic         flush;
    logic [1:0]   hazard;
    logic         stall;
    logic [127:0] busy;
    logic [7:0]   busy_cnt;

    int checks = 0;
    int errors = 0;

    spu_issue_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rt    (issue_rt),
        .issue_lat   (issue_lat),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .flush       (flush),
        .hazard      (hazard),
        .stall       (stall),
        .busy        (busy),
        .busy_cnt    (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = '0;
        issue_wr    = '0;
        issue_rt    = '0;
        issue_lat   = '0;
        src_addr    = '0;
        src_used    = '0;
        flush       = 1'b0;
    endtask

    task automatic set_issue(input int p, input logic wr, input logic [6:0] rt, input logic [2:0] lat);
        issue_valid[p]       = 1'b1;
        issue_wr[p]          = wr;
        issue_rt[p*7 +: 7]   = rt;
        issue_lat[p*3 +: 3]  = lat;
    endtask

    task automatic set_src(input int p, input int s, input logic [6:0] addr);
        src_used[p*3+s]           = 1'b1;
        src_addr[(p*3+s)*7 +: 7]  = addr;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 128'd0);
        chk("rst_busy_cnt", {120'd0, busy_cnt}, 128'd0);
        set_issue(0, 1'b1, 7'd3, 3'd4);
        issue_valid[1] = 1'b1;
        set_src(1, 2, 7'd3);
        #1;
        chk("rst_hazard", {126'd0, hazard}, 128'd0);
        chk("rst_stall", {127'd0, stall}, 128'd0);
        tick();
        chk("rst_ignores_issue", busy, 128'd0);
        reset = 1'b1;
        idle();
        tick();

        // single issue rt=1 L=2, then repeated reads of ra=1
        set_issue(0, 1'b1, 7'd1, 3'd2);
        #1;
        chk("raw_issue_hazard", {126'd0, hazard}, 128'd0);
        tick();
        chk("raw_busy_t1", busy, 128'd1 << 1);
        idle();
        issue_valid[0] = 1'b1;
        set_src(0, 0, 7'd1);
        #1;
        chk("raw_hazard_t1", {126'd0, hazard}, 128'd1);
        chk("raw_stall_t1", {127'd0, stall}, 128'd1);
        tick();
        chk("raw_busy_t2", busy, 128'd1 << 1);
        chk("raw_hazard_t2", {126'd0, hazard}, 128'd1);
        tick();
        chk("raw_busy_t3", busy, 128'd0);
        chk("raw_hazard_t3", {126'd0, hazard}, 128'd0);
        idle();

        // intra-bundle RAW: pipe1 rc reads pipe0 rt
        set_issue(0, 1'b1, 7'd3, 3'd4);
        issue_valid[1] = 1'b1;
        set_src(1, 2, 7'd3);
        #1;
        chk("intra_hazard_a", {126'd0, hazard}, 128'd2);
        chk("intra_stall_a", {127'd0, stall}, 128'd1);
        tick();
        chk("intra_no_load", busy, 128'd0);
        chk("intra_hazard_b", {126'd0, hazard}, 128'd2);
        tick();
        chk("intra_no_load_b", busy, 128'd0);
        idle();

        // WAW: rt=5 on both pipes, L=6 and L=2
        set_issue(0, 1'b1, 7'd5, 3'd6);
        set_issue(1, 1'b1, 7'd5, 3'd2);
        #1;
        chk("waw_hazard", {126'd0, hazard}, 128'd0);
        tick();
        idle();
        chk("waw_busy_cnt", {120'd0, busy_cnt}, 128'd1);
        chk("waw_busy_0", busy, 128'd1 << 5);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("waw_busy_%0d", i), busy, (i < 6) ? (128'd1 << 5) : 128'd0);
        end

        // reissue over pending register: max(decremented, new latency)
        set_issue(0, 1'b1, 7'd2, 3'd7);
        tick();
        idle();
        tick();
        tick();
        chk("reissue_pending", busy, 128'd1 << 2);
        set_issue(0, 1'b1, 7'd2, 3'd3);
        tick();
        idle();
        chk("reissue_busy_0", busy, 128'd1 << 2);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("reissue_busy_%0d", i), busy, (i < 4) ? (128'd1 << 2) : 128'd0);
        end

        // flush beats a same-cycle issue
        set_issue(0, 1'b1, 7'd11, 3'd7);
        set_issue(1, 1'b1, 7'd12, 3'd7);
        tick();
        idle();
        set_issue(0, 1'b1, 7'd13, 3'd7);
        tick();
        idle();
        chk("flush_pre_cnt", {120'd0, busy_cnt}, 128'd3);
        chk("flush_pre_busy", busy, (128'd1 << 11) | (128'd1 << 12) | (128'd1 << 13));
        flush = 1'b1;
        set_issue(0, 1'b1, 7'd9, 3'd5);
        #1;
        chk("flush_hazard", {126'd0, hazard}, 128'd0);
        tick();
        chk("flush_busy", busy, 128'd0);
        chk("flush_busy_cnt", {120'd0, busy_cnt}, 128'd0);
        idle();
        tick();
        chk("flush_rt9_untracked", busy, 128'd0);

        // mid-operation reset discards pending write
        set_issue(0, 1'b1, 7'd10, 3'd7);
        tick();
        idle();
        chk("mrst_pending", busy, 128'd1 << 10);
        reset = 1'b0;
        tick();
        chk("mrst_busy", busy, 128'd0);
        chk("mrst_busy_cnt", {120'd0, busy_cnt}, 128'd0);
        reset = 1'b1;
        issue_valid[0] = 1'b1;
        set_src(0, 0, 7'd10);
        #1;
        chk("mrst_hazard", {126'd0, hazard}, 128'd0);
        tick();
        idle();

        // register 0 tracked; zero latency untracked everywhere
        set_issue(0, 1'b1, 7'd0, 3'd0);
        tick();
        idle();
        chk("lat0_untracked", busy, 128'd0);
        set_issue(0, 1'b1, 7'd0, 3'd1);
        tick();
        idle();
        chk("reg0_busy", busy, 128'd1);
        chk("reg0_busy_cnt", {120'd0, busy_cnt}, 128'd1);
        set_issue(0, 1'b1, 7'd4, 3'd0);
        issue_valid[1] = 1'b1;
        set_src(1, 0, 7'd4);
        #1;
        chk("lat0_intra_hazard", {126'd0, hazard}, 128'd0);
        tick();
        idle();
        chk("reg0_cleared", busy, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
